// File: rtl/liang_pkg.sv
// Shared core types: uop encoding, load/store kinds and the LSU memory request.
// Latency: n/a (types only).
// Backpressure: n/a.
package liang_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        LOAD_NONE,
        LOAD_LB,
        LOAD_LH,
        LOAD_LW,
        LOAD_LD,
        LOAD_LBU,
        LOAD_LHU,
        LOAD_LWU
    } load_type_e;

    typedef enum logic [2:0] {
        STORE_NONE,
        STORE_SB,
        STORE_SH,
        STORE_SW,
        STORE_SD
    } store_type_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rd;
        load_type_e  load_type;
        store_type_e store_type;
    } uop_info_t;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_RSP,
        LSU_DONE
    } lsu_state_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  wen;
        logic [DATA_WIDTH-1:0] wdata;
        logic [STRB_WIDTH-1:0] wstrb;
    } mem_req_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store data/strobes, load extraction/extension, alignment check.
// Latency: purely combinational.
// Backpressure: none; the caller registers the results.
module lsu_lane_align
    import liang_pkg::*;
(
    input  load_type_e                acc_load_type,
    input  store_type_e               acc_store_type,
    input  logic [1:0]                acc_off,
    input  logic [31:0]               st_data,
    output logic [DATA_WIDTH-1:0]     st_wdata,
    output logic [STRB_WIDTH-1:0]     st_wstrb,
    output logic                      misalign,
    input  load_type_e                rsp_load_type,
    input  logic [1:0]                rsp_off,
    input  logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [31:0]               ld_res
);

    logic [STRB_WIDTH-1:0] base_mask;
    logic [DATA_WIDTH-1:0] shifted;
    logic                  ld_bad;
    logic                  st_bad;

    always_comb begin
        base_mask = '0;
        case (acc_store_type)
            STORE_SB: base_mask = 4'b0001;
            STORE_SH: base_mask = 4'b0011;
            STORE_SW: base_mask = 4'b1111;
            default:  base_mask = '0;
        endcase
        st_wdata = st_data << {acc_off, 3'b000};
        st_wstrb = base_mask << acc_off;
    end

    // 64-bit and word-unsigned kinds have no path on a 32-bit port, so they fault like misalignment.
    always_comb begin
        ld_bad = 1'b0;
        case (acc_load_type)
            LOAD_LH, LOAD_LHU: ld_bad = acc_off[0];
            LOAD_LW:           ld_bad = (acc_off != 2'b00);
            LOAD_LD, LOAD_LWU: ld_bad = 1'b1;
            default:           ld_bad = 1'b0;
        endcase
        st_bad = 1'b0;
        case (acc_store_type)
            STORE_SH: st_bad = acc_off[0];
            STORE_SW: st_bad = (acc_off != 2'b00);
            STORE_SD: st_bad = 1'b1;
            default:  st_bad = 1'b0;
        endcase
        misalign = ld_bad | st_bad;
    end

    always_comb begin
        shifted = rsp_rdata >> {rsp_off, 3'b000};
        ld_res  = '0;
        case (rsp_load_type)
            LOAD_LB:  ld_res = {{24{shifted[7]}}, shifted[7:0]};
            LOAD_LBU: ld_res = {24'h0, shifted[7:0]};
            LOAD_LH:  ld_res = {{16{shifted[15]}}, shifted[15:0]};
            LOAD_LHU: ld_res = {16'h0, shifted[15:0]};
            LOAD_LW:  ld_res = shifted;
            default:  ld_res = '0;
        endcase
    end

endmodule

// File: rtl/lsu_unit.sv
// Execute-stage load/store unit, one access in flight on a valid/ready memory port.
// Latency: memory op accept->out_valid 3 cycles; bypass/misaligned 1 cycle.
// Backpressure: in_ready only in IDLE; request and result held stable until their ready.
module lsu_unit
    import liang_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  uop_info_t              in_uop,
    input  logic [31:0]            in_rs1_rdata,
    input  logic [31:0]            in_rs2_rdata,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic [ADDR_WIDTH-1:0]  mem_req_addr,
    output logic                   mem_req_wen,
    output logic [DATA_WIDTH-1:0]  mem_req_wdata,
    output logic [STRB_WIDTH-1:0]  mem_req_wstrb,
    input  logic                   mem_rsp_valid,
    output logic                   mem_rsp_ready,
    input  logic [DATA_WIDTH-1:0]  mem_rsp_rdata,
    output logic                   out_valid,
    input  logic                   out_ready,
    output uop_info_t              out_uop,
    output logic [31:0]            out_lsu_res,
    output logic                   out_misalign
);

    lsu_state_e            state_q;
    lsu_state_e            state_d;
    uop_info_t             uop_q;
    mem_req_t              req_q;
    logic [1:0]            off_q;
    logic [31:0]           res_q;
    logic                  misalign_q;

    logic [ADDR_WIDTH-1:0] ea;
    logic                  acc_wen;
    logic [DATA_WIDTH-1:0] acc_wdata;
    logic [STRB_WIDTH-1:0] acc_wstrb;
    logic                  acc_misalign;
    logic [31:0]           ld_res;
    logic                  acc_bypass;

    assign ea         = in_rs1_rdata + in_uop.imm;
    assign acc_wen    = (in_uop.store_type != STORE_NONE);
    assign acc_bypass = (in_uop.load_type == LOAD_NONE) && (in_uop.store_type == STORE_NONE);

    lsu_lane_align u_align (
        .acc_load_type  (in_uop.load_type),
        .acc_store_type (in_uop.store_type),
        .acc_off        (ea[1:0]),
        .st_data        (in_rs2_rdata),
        .st_wdata       (acc_wdata),
        .st_wstrb       (acc_wstrb),
        .misalign       (acc_misalign),
        .rsp_load_type  (uop_q.load_type),
        .rsp_off        (off_q),
        .rsp_rdata      (mem_rsp_rdata),
        .ld_res         (ld_res)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= LSU_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        in_ready      = 1'b0;
        mem_req_valid = 1'b0;
        mem_rsp_ready = 1'b0;
        out_valid     = 1'b0;
        case (state_q)
            LSU_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = (acc_misalign || acc_bypass) ? LSU_DONE : LSU_REQ;
                end
            end
            LSU_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_d = LSU_RSP;
            end
            LSU_RSP: begin
                mem_rsp_ready = 1'b1;
                if (mem_rsp_valid) state_d = LSU_DONE;
            end
            LSU_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = LSU_IDLE;
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    // Loads carry an all-zero strobe so the memory never sees byte enables on a read.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            uop_q      <= '0;
            req_q      <= '0;
            off_q      <= '0;
            res_q      <= '0;
            misalign_q <= 1'b0;
        end else begin
            case (state_q)
                LSU_IDLE: begin
                    if (in_valid) begin
                        uop_q       <= in_uop;
                        off_q       <= ea[1:0];
                        req_q.addr  <= {ea[ADDR_WIDTH-1:2], 2'b00};
                        req_q.wen   <= acc_wen;
                        req_q.wdata <= acc_wdata;
                        req_q.wstrb <= acc_wen ? acc_wstrb : '0;
                        res_q       <= '0;
                        misalign_q  <= acc_misalign;
                    end
                end
                LSU_RSP: begin
                    if (mem_rsp_valid) begin
                        res_q <= req_q.wen ? 32'h0 : ld_res;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_req_addr  = req_q.addr;
    assign mem_req_wen   = req_q.wen;
    assign mem_req_wdata = req_q.wdata;
    assign mem_req_wstrb = req_q.wstrb;
    assign out_uop       = uop_q;
    assign out_lsu_res   = res_q;
    assign out_misalign  = misalign_q;

endmodule

// File: tb/tb_lsu_unit.sv
// Scoreboarded bench for lsu_unit: directed uops, memory/WB stalls, back-to-back and reset abort.
module tb_lsu_unit;
    import liang_pkg::*;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  in_valid;
    logic                  in_ready;
    uop_info_t             in_uop;
    logic [31:0]           in_rs1_rdata;
    logic [31:0]           in_rs2_rdata;
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic                  mem_req_wen;
    logic [DATA_WIDTH-1:0] mem_req_wdata;
    logic [STRB_WIDTH-1:0] mem_req_wstrb;
    logic                  mem_rsp_valid;
    logic                  mem_rsp_ready;
    logic [DATA_WIDTH-1:0] mem_rsp_rdata;
    logic                  out_valid;
    logic                  out_ready;
    uop_info_t             out_uop;
    logic [31:0]           out_lsu_res;
    logic                  out_misalign;

    lsu_unit dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_uop        (in_uop),
        .in_rs1_rdata  (in_rs1_rdata),
        .in_rs2_rdata  (in_rs2_rdata),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wen   (mem_req_wen),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_wstrb (mem_req_wstrb),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_ready (mem_rsp_ready),
        .mem_rsp_rdata (mem_rsp_rdata),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_uop       (out_uop),
        .out_lsu_res   (out_lsu_res),
        .out_misalign  (out_misalign)
    );

    initial forever #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_exp_t;

    typedef struct {
        uop_info_t   uop;
        logic [31:0] res;
        logic        mis;
        int          lat;
    } out_exp_t;

    req_exp_t req_q[$];
    out_exp_t out_q[$];
    int       acc_hist[$];
    int       cyc = 0;
    int       n_cmp = 0;
    int       n_bad = 0;
    int       acc_cyc = 0;
    int       first_out_cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic wait_for(input int which, input string nm);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            @(negedge clock);
            case (which)
                0:       hit = mem_req_valid;
                1:       hit = mem_rsp_ready;
                2:       hit = out_valid;
                default: hit = in_ready;
            endcase
        end
        if (!hit) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout_%s: stayed 0 for 60 cycles, expected 1", nm);
        end
    endtask

    // Monitor: pops expectations on each handshake and checks hold-stability while stalled.
    bit          prev_req_stall = 1'b0;
    bit          prev_out_stall = 1'b0;
    bit          prev_out_v = 1'b0;
    logic [31:0] sv_addr;
    logic [31:0] sv_wdata;
    logic [3:0]  sv_wstrb;
    logic        sv_wen;
    uop_info_t   sv_uop;
    logic [31:0] sv_res;
    logic        sv_mis;

    always @(negedge clock) begin
        req_exp_t re;
        out_exp_t oe;
        if (reset) begin
            prev_req_stall = 1'b0;
            prev_out_stall = 1'b0;
            prev_out_v     = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                acc_cyc = cyc;
                acc_hist.push_back(cyc);
            end
            if (mem_req_valid || mem_rsp_ready || out_valid) check("in_ready_while_busy", in_ready, 0);
            if (prev_req_stall) begin
                check("req_hold_valid", mem_req_valid, 1);
                check("req_hold_addr", mem_req_addr, sv_addr);
                check("req_hold_wdata", mem_req_wdata, sv_wdata);
                check("req_hold_wstrb", mem_req_wstrb, sv_wstrb);
                check("req_hold_wen", mem_req_wen, sv_wen);
            end
            if (prev_out_stall) begin
                check("out_hold_valid", out_valid, 1);
                check("out_hold_uop", out_uop, sv_uop);
                check("out_hold_res", out_lsu_res, sv_res);
                check("out_hold_mis", out_misalign, sv_mis);
            end
            if (out_valid && !prev_out_v) first_out_cyc = cyc;
            if (mem_req_valid) begin
                check("req_expected", req_q.size() != 0, 1);
                if (mem_req_ready && req_q.size() != 0) begin
                    re = req_q.pop_front();
                    check("req_addr", mem_req_addr, re.addr);
                    check("req_wen", mem_req_wen, re.wen);
                    check("req_wstrb", mem_req_wstrb, re.wstrb);
                    if (re.wen) check("req_wdata", mem_req_wdata, re.wdata);
                end
            end
            if (out_valid) begin
                check("out_expected", out_q.size() != 0, 1);
                if (out_ready && out_q.size() != 0) begin
                    oe = out_q.pop_front();
                    check("out_uop", out_uop, oe.uop);
                    check("out_lsu_res", out_lsu_res, oe.res);
                    check("out_misalign", out_misalign, oe.mis);
                    if (oe.lat >= 0) check("out_latency", first_out_cyc - acc_cyc, oe.lat);
                end
            end
            prev_req_stall = mem_req_valid && !mem_req_ready;
            prev_out_stall = out_valid && !out_ready;
            prev_out_v     = out_valid;
            sv_addr  = mem_req_addr;
            sv_wdata = mem_req_wdata;
            sv_wstrb = mem_req_wstrb;
            sv_wen   = mem_req_wen;
            sv_uop   = out_uop;
            sv_res   = out_lsu_res;
            sv_mis   = out_misalign;
        end
    end

    function automatic uop_info_t mk(input logic [31:0] pc, input logic [31:0] imm,
                                     input load_type_e lt, input store_type_e st);
        uop_info_t u;
        u            = '0;
        u.pc         = pc;
        u.imm        = imm;
        u.rd         = pc[4:0];
        u.load_type  = lt;
        u.store_type = st;
        return u;
    endfunction

    task automatic run_op(input uop_info_t u, input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [31:0] rdata, input bit mem,
                          input logic [31:0] e_addr, input logic e_wen, input logic [31:0] e_wdata,
                          input logic [3:0] e_wstrb, input logic [31:0] e_res, input logic e_mis,
                          input int lat, input int rq_st, input int rs_dl, input int o_st);
        if (mem) req_q.push_back('{e_addr, e_wen, e_wdata, e_wstrb});
        out_q.push_back('{u, e_res, e_mis, lat});
        wait_for(3, "in_ready");
        @(posedge clock); #1;
        in_valid     = 1'b1;
        in_uop       = u;
        in_rs1_rdata = rs1;
        in_rs2_rdata = rs2;
        @(posedge clock); #1;
        in_valid = 1'b0;
        if (mem) begin
            for (int i = 0; i < rq_st; i++) begin @(posedge clock); #1; end
            mem_req_ready = 1'b1;
            wait_for(0, "mem_req_valid");
            @(posedge clock); #1;
            mem_req_ready = 1'b0;
            for (int i = 0; i < rs_dl; i++) begin @(posedge clock); #1; end
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = rdata;
            wait_for(1, "mem_rsp_ready");
            @(posedge clock); #1;
            mem_rsp_valid = 1'b0;
        end
        for (int i = 0; i < o_st; i++) begin @(posedge clock); #1; end
        out_ready = 1'b1;
        wait_for(2, "out_valid");
        @(posedge clock); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_uop = '0; in_rs1_rdata = '0; in_rs2_rdata = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0; out_ready = 1'b0;
        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_mem_req_valid", mem_req_valid, 0);
        check("rst_mem_rsp_ready", mem_rsp_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_req_fields", {mem_req_addr, mem_req_wdata, mem_req_wstrb, mem_req_wen}, 0);
        check("rst_out_fields", {out_uop, out_lsu_res, out_misalign}, 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // uop, rs1, rs2, rdata, mem, addr, wen, wdata, wstrb, res, mis, lat, req_stall, rsp_delay, out_stall
        run_op(mk(32'h100, 32'd3, LOAD_LB, STORE_NONE), 32'h8000_0000, 32'h0, 32'h8011_2233, 1,
               32'h8000_0000, 0, 32'h0, 4'b0000, 32'hFFFF_FF80, 0, 3, 0, 0, 0);
        run_op(mk(32'h104, 32'd3, LOAD_LBU, STORE_NONE), 32'h8000_0000, 32'h0, 32'h8011_2233, 1,
               32'h8000_0000, 0, 32'h0, 4'b0000, 32'h0000_0080, 0, 3, 0, 0, 0);
        run_op(mk(32'h108, 32'd2, LOAD_NONE, STORE_SH), 32'h8000_0000, 32'h1234_ABCD, 32'h0, 1,
               32'h8000_0000, 1, 32'hABCD_0000, 4'b1100, 32'h0, 0, 3, 0, 0, 0);
        run_op(mk(32'h10C, 32'd1, LOAD_LW, STORE_NONE), 32'h8000_0000, 32'h0, 32'h0, 0,
               32'h0, 0, 32'h0, 4'b0000, 32'h0, 1, 1, 0, 0, 0);
        run_op(mk(32'h110, 32'h10, LOAD_LW, STORE_NONE), 32'h8000_0000, 32'h0, 32'hDEAD_BEEF, 1,
               32'h8000_0010, 0, 32'h0, 4'b0000, 32'hDEAD_BEEF, 0, -1, 4, 3, 5);
        run_op(mk(32'h114, 32'd2, LOAD_LH, STORE_NONE), 32'h8000_0000, 32'h0, 32'h8011_2233, 1,
               32'h8000_0000, 0, 32'h0, 4'b0000, 32'hFFFF_8011, 0, 3, 0, 0, 0);
        run_op(mk(32'h118, 32'd2, LOAD_LHU, STORE_NONE), 32'h8000_0000, 32'h0, 32'h8011_2233, 1,
               32'h8000_0000, 0, 32'h0, 4'b0000, 32'h0000_8011, 0, 3, 0, 0, 0);
        run_op(mk(32'h11C, 32'd1, LOAD_NONE, STORE_SB), 32'h8000_0000, 32'h0000_00AB, 32'h0, 1,
               32'h8000_0000, 1, 32'h0000_AB00, 4'b0010, 32'h0, 0, 3, 0, 0, 0);
        run_op(mk(32'h120, 32'd1, LOAD_NONE, STORE_SH), 32'h8000_0000, 32'h0000_1111, 32'h0, 0,
               32'h0, 0, 32'h0, 4'b0000, 32'h0, 1, 1, 0, 0, 0);
        run_op(mk(32'h124, 32'd0, LOAD_LD, STORE_NONE), 32'h8000_0000, 32'h0, 32'h0, 0,
               32'h0, 0, 32'h0, 4'b0000, 32'h0, 1, 1, 0, 0, 0);
        run_op(mk(32'h128, 32'd0, LOAD_NONE, STORE_NONE), 32'h8000_0000, 32'h0, 32'h0, 0,
               32'h0, 0, 32'h0, 4'b0000, 32'h0, 0, 1, 0, 0, 0);
        run_op(mk(32'h12C, 32'd4, LOAD_LB, STORE_NONE), 32'h8000_0000, 32'h0, 32'h0000_007F, 1,
               32'h8000_0004, 0, 32'h0, 4'b0000, 32'h0000_007F, 0, 3, 0, 0, 0);

        // Back-to-back with every ready held high.
        req_q.push_back('{32'h8000_0020, 1'b0, 32'h0, 4'b0000});
        out_q.push_back('{mk(32'h200, 32'd0, LOAD_LW, STORE_NONE), 32'h0BAD_F00D, 1'b0, 3});
        req_q.push_back('{32'h8000_0024, 1'b1, 32'h5566_7788, 4'b1111});
        out_q.push_back('{mk(32'h204, 32'd0, LOAD_NONE, STORE_SW), 32'h0, 1'b0, 3});
        req_q.push_back('{32'h8000_0028, 1'b0, 32'h0, 4'b0000});
        out_q.push_back('{mk(32'h208, 32'd0, LOAD_LW, STORE_NONE), 32'h0BAD_F00D, 1'b0, 3});
        wait_for(3, "in_ready");
        @(posedge clock); #1;
        acc_hist.delete();
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h0BAD_F00D; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid     = 1'b1;
            in_uop       = mk(32'h200 + 32'(4 * k), 32'd0, (k == 1) ? LOAD_NONE : LOAD_LW,
                              (k == 1) ? STORE_SW : STORE_NONE);
            in_rs1_rdata = 32'h8000_0020 + 32'(4 * k);
            in_rs2_rdata = 32'h5566_7788;
            wait_for(3, "in_ready_b2b");
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; out_ready = 1'b0;
        check("b2b_accepts", acc_hist.size(), 3);
        if (acc_hist.size() == 3) begin
            check("b2b_gap_0", acc_hist[1] - acc_hist[0], 4);
            check("b2b_gap_1", acc_hist[2] - acc_hist[1], 4);
        end

        // Reset while waiting for a load response.
        req_q.push_back('{32'h8000_0040, 1'b0, 32'h0, 4'b0000});
        wait_for(3, "in_ready_rst");
        @(posedge clock); #1;
        in_valid = 1'b1; in_uop = mk(32'h300, 32'd0, LOAD_LW, STORE_NONE); in_rs1_rdata = 32'h8000_0040;
        @(posedge clock); #1;
        in_valid = 1'b0; mem_req_ready = 1'b1;
        wait_for(0, "mem_req_valid_rst");
        @(posedge clock); #1;
        mem_req_ready = 1'b0;
        check("pre_rst_rsp_ready", mem_rsp_ready, 1);
        reset = 1'b1;
        #1;
        check("rst_rsp_out_valid", out_valid, 0);
        check("rst_rsp_mem_rsp_ready", mem_rsp_ready, 0);
        check("rst_rsp_in_ready", in_ready, 1);
        @(posedge clock); #1;
        reset = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h1111_1111;
        repeat (2) @(posedge clock);
        #1 mem_rsp_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check("post_rst_out_valid", out_valid, 0);
            check("post_rst_rsp_ready", mem_rsp_ready, 0);
        end

        check("req_queue_drained", req_q.size(), 0);
        check("out_queue_drained", out_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
